// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared definitions for the data-cache memory controller and the cache controllers that talk to it.
package dcache_mem_ctrl_pkg;

  localparam int unsigned MEM_ADDRESS_LEN   = 16;
  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  // Low address bits that select a byte inside a line.
  localparam int unsigned BYTE_IN_LINE_W    = 4;
  localparam int unsigned DEFAULT_LATENCY   = 10;

  // Controller states; the cache controllers decode these same encodings.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWbWait   = 2'd1,
    StFillWait = 2'd2,
    StRespond  = 2'd3
  } mem_state_e;

  // Width of the line index for a given byte-address width.
  function automatic int unsigned line_idx_width(input int unsigned addr_w);
    return addr_w - BYTE_IN_LINE_W;
  endfunction

endpackage

// File: rtl/dcache_mem_ctrl_array.sv
// Single-port line-wide storage with synchronous write and registered read.
module mem_line_array #(
  parameter int unsigned IdxWidth  = 12,
  parameter int unsigned LineWidth = 128,
  parameter string       InitFile  = ""
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  idx_i,
  input  logic [LineWidth-1:0] wdata_i,
  output logic [LineWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << IdxWidth;

  // Contents survive reset, so the storage has no reset branch.
  logic [LineWidth-1:0] mem_q [Depth];
  logic [LineWidth-1:0] rdata_q;

  // Write on enable; read is registered and returns the pre-write contents on a collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Main-memory controller behind the data cache: serves one line fill or write-back at a time
// after a fixed access latency.
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = MEM_ADDRESS_LEN,
  parameter int unsigned LINE_WIDTH    = DCACHE_LINE_WIDTH,
  parameter int unsigned LATENCY       = DEFAULT_LATENCY,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_dCache_mem,
  input  logic [ADDR_WIDTH-1:0] req_dCache_mem_addr,
  input  logic                  req_wb,
  input  logic [ADDR_WIDTH-1:0] req_wb_addr,
  input  logic [LINE_WIDTH-1:0] req_wb_data,
  output logic [LINE_WIDTH-1:0] data_to_fill,
  output logic                  mem_data_rdy,
  output logic                  wb_done,
  output logic                  mem_busy
);

  localparam int unsigned   IdxW    = line_idx_width(ADDR_WIDTH);
  localparam int unsigned   CntW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  mem_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [LINE_WIDTH-1:0] wb_data_q;
  logic [LINE_WIDTH-1:0] fill_data_q;
  logic                  rdy_q;
  logic                  wb_done_q;

  logic                  arr_we;
  logic [LINE_WIDTH-1:0] arr_rdata;

  // Byte-in-line address bits carry no information for a line-wide memory.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{req_dCache_mem_addr[BYTE_IN_LINE_W-1:0],
                              req_wb_addr[BYTE_IN_LINE_W-1:0]};

  // The write strobe decodes only registered state, so an asynchronous reset cancels it at once.
  assign arr_we = (state_q == StWbWait) && (cnt_q == '0);

  mem_line_array #(
    .IdxWidth  (IdxW),
    .LineWidth (LINE_WIDTH),
    .InitFile  (MEM_INIT_FILE)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .idx_i   (idx_q),
    .wdata_i (wb_data_q),
    .rdata_o (arr_rdata)
  );

  // Request arbitration, latency countdown and registered completion pulses.
  // The array is read every cycle at the latched index; with LATENCY >= 2 the read data is
  // already valid for that index when the fill countdown expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
      rdy_q       <= 1'b0;
      wb_done_q   <= 1'b0;
    end else begin
      rdy_q     <= 1'b0;
      wb_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Write-back has priority so an evicted line lands before any refill of it.
          if (req_wb) begin
            idx_q     <= req_wb_addr[ADDR_WIDTH-1:BYTE_IN_LINE_W];
            wb_data_q <= req_wb_data;
            cnt_q     <= CntLoad;
            state_q   <= StWbWait;
          end else if (req_dCache_mem) begin
            idx_q   <= req_dCache_mem_addr[ADDR_WIDTH-1:BYTE_IN_LINE_W];
            cnt_q   <= CntLoad;
            state_q <= StFillWait;
          end
        end
        StWbWait: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // Pulse during the last waiting cycle, which ends with the array write.
            if (cnt_q == CntOne) begin
              wb_done_q <= 1'b1;
            end
          end
        end
        StFillWait: begin
          if (cnt_q == '0) begin
            fill_data_q <= arr_rdata;
            rdy_q       <= 1'b1;
            state_q     <= StRespond;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRespond: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_to_fill = fill_data_q;
  assign mem_data_rdy = rdy_q;
  assign wb_done      = wb_done_q;
  assign mem_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Randomized self-checking bench for dcache_mem_ctrl against a line-level memory model.
module tb_dcache_mem_ctrl;

  localparam int Lat    = 10;
  localparam int Budget = 8 * Lat;

  logic         clk;
  logic         rst_n;
  logic         req_dCache_mem;
  logic [15:0]  req_dCache_mem_addr;
  logic         req_wb;
  logic [15:0]  req_wb_addr;
  logic [127:0] req_wb_data;
  logic [127:0] data_to_fill;
  logic         mem_data_rdy;
  logic         wb_done;
  logic         mem_busy;

  // Second instance built with the minimum latency.
  logic         req2_fill;
  logic [15:0]  req2_fill_addr;
  logic         req2_wb;
  logic [15:0]  req2_wb_addr;
  logic [127:0] req2_wb_data;
  logic [127:0] data2_to_fill;
  logic         mem2_data_rdy;
  logic         wb2_done;
  logic         mem2_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: line index -> contents, only for lines this bench has written.
  logic [127:0] model [int];

  dcache_mem_ctrl #(
    .ADDR_WIDTH (16),
    .LINE_WIDTH (128),
    .LATENCY    (Lat)
  ) u_dut (
    .clk                 (clk),
    .reset               (rst_n),
    .req_dCache_mem      (req_dCache_mem),
    .req_dCache_mem_addr (req_dCache_mem_addr),
    .req_wb              (req_wb),
    .req_wb_addr         (req_wb_addr),
    .req_wb_data         (req_wb_data),
    .data_to_fill        (data_to_fill),
    .mem_data_rdy        (mem_data_rdy),
    .wb_done             (wb_done),
    .mem_busy            (mem_busy)
  );

  dcache_mem_ctrl #(
    .ADDR_WIDTH (16),
    .LINE_WIDTH (128),
    .LATENCY    (2)
  ) u_dut_lat2 (
    .clk                 (clk),
    .reset               (rst_n),
    .req_dCache_mem      (req2_fill),
    .req_dCache_mem_addr (req2_fill_addr),
    .req_wb              (req2_wb),
    .req_wb_addr         (req2_wb_addr),
    .req_wb_data         (req2_wb_data),
    .data_to_fill        (data2_to_fill),
    .mem_data_rdy        (mem2_data_rdy),
    .wb_done             (wb2_done),
    .mem_busy            (mem2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a fill and/or write-back from the input phase (#1 after an edge). Edge count n=1 is
  // the accept edge E; a pulse first seen at the negedge after edge E+k reports n=k+1.
  // With late_wb, once the fill is accepted the fill address is scrambled and a write-back
  // is raised, both of which must be ignored until the controller is idle again.
  task automatic run_req(input bit do_fill, input logic [15:0] fa,
                         input bit do_wb, input logic [15:0] wa, input logic [127:0] wd,
                         input bit late_wb,
                         output int nr, output int nw, output logic [127:0] rdata);
    int n;
    bit want_wb;
    n = 0;
    nr = 0;
    nw = 0;
    rdata = '0;
    want_wb = do_wb || late_wb;
    req_dCache_mem      = do_fill;
    req_dCache_mem_addr = fa;
    req_wb              = do_wb;
    req_wb_addr         = wa;
    req_wb_data         = wd;
    while (((do_fill && nr == 0) || (want_wb && nw == 0)) && n < Budget) begin
      @(posedge clk);
      n++;
      #1;
      if (nr != 0) req_dCache_mem = 1'b0;
      if (nw != 0) req_wb = 1'b0;
      if (late_wb && n == 1) begin
        req_dCache_mem_addr = 16'hF000;
        req_wb              = 1'b1;
        req_wb_addr         = wa;
        req_wb_data         = wd;
      end
      @(negedge clk);
      if (wb_done && nw == 0) nw = n;
      if (mem_data_rdy && nr == 0) begin
        nr    = n;
        rdata = data_to_fill;
      end
    end
    @(posedge clk);
    #1;
    req_dCache_mem = 1'b0;
    req_wb         = 1'b0;
    @(negedge clk);
    check_eq("rdy_one_cycle", mem_data_rdy, 1'b0);
    check_eq("wb_done_one_cycle", wb_done, 1'b0);
    check_eq("idle_after_done", mem_busy, 1'b0);
    if (do_fill) check_eq("fill_data_hold", data_to_fill, rdata);
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [15:0] a, input logic [127:0] d);
    int nr, nw;
    logic [127:0] rd;
    run_req(1'b0, 16'h0, 1'b1, a, d, 1'b0, nr, nw, rd);
    check_eq("wb_latency", nw, Lat);
    model[int'(a[15:4])] = d;
  endtask

  task automatic do_fill(input logic [15:0] a);
    int nr, nw;
    logic [127:0] rd;
    run_req(1'b1, a, 1'b0, 16'h0, '0, 1'b0, nr, nw, rd);
    check_eq("fill_latency", nr, Lat + 1);
    check_eq("fill_data", rd, model[int'(a[15:4])]);
  endtask

  // Accept a request, pull reset 4 edges after acceptance and confirm nothing completes.
  task automatic reset_mid(input bit is_wb, input logic [15:0] a, input logic [127:0] d);
    int pulses;
    req_dCache_mem      = !is_wb;
    req_dCache_mem_addr = a;
    req_wb              = is_wb;
    req_wb_addr         = a;
    req_wb_data         = d;
    repeat (5) @(posedge clk);
    #1;
    rst_n          = 1'b0;
    req_dCache_mem = 1'b0;
    req_wb         = 1'b0;
    #1;
    check_eq("rst_mid_busy", mem_busy, 1'b0);
    check_eq("rst_mid_rdy", mem_data_rdy, 1'b0);
    check_eq("rst_mid_data", data_to_fill, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (3 * Lat) begin
      @(negedge clk);
      if (mem_data_rdy || wb_done || mem_busy) pulses++;
    end
    check_eq("rst_mid_no_completion", pulses, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses, nr, nw, n;
    logic [127:0] rd, d;
    logic [15:0]  a, fa;
    logic [11:0]  pool [16];

    rst_n = 1'b0;
    req_dCache_mem = 1'b0; req_dCache_mem_addr = '0;
    req_wb = 1'b0; req_wb_addr = '0; req_wb_data = '0;
    req2_fill = 1'b0; req2_fill_addr = '0;
    req2_wb = 1'b0; req2_wb_addr = '0; req2_wb_data = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy", mem_data_rdy, 1'b0);
    check_eq("rst_wb_done", wb_done, 1'b0);
    check_eq("rst_busy", mem_busy, 1'b0);
    check_eq("rst_data", data_to_fill, '0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_data_rdy || wb_done || mem_busy) pulses++;
    end
    check_eq("idle_no_pulses", pulses, 0);
    @(posedge clk);
    #1;

    // Write-back then fill of the same line through a different byte offset.
    do_wb(16'h0050, 128'h0011_0101_0011_0101_0011_0101_0011_0101);
    do_fill(16'h0053);

    // Simultaneous requests: write-back first, then the fill returns the new line.
    d = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    run_req(1'b1, 16'h00A4, 1'b1, 16'h00A0, d, 1'b0, nr, nw, rd);
    model[int'(12'h00A)] = d;
    check_eq("simul_wb_latency", nw, Lat);
    check_eq("simul_fill_latency", nr, 2 * Lat + 2);
    check_eq("simul_fill_data", rd, d);

    // Inputs changed while busy: fill keeps its address, write-back waits for idle.
    d = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    run_req(1'b1, 16'h0050, 1'b0, 16'h0060, d, 1'b1, nr, nw, rd);
    check_eq("busy_fill_latency", nr, Lat + 1);
    check_eq("busy_fill_data", rd, model[int'(12'h005)]);
    check_eq("busy_wb_latency", nw, 2 * Lat + 2);
    model[int'(12'h006)] = d;
    do_fill(16'h006F);

    // Reset mid-fill, then mid-write-back with the line still holding its old value.
    reset_mid(1'b0, 16'h0050, '0);
    reset_mid(1'b1, 16'h0050, 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0);
    do_fill(16'h0050);

    // Randomized traffic over a small pool of lines.
    for (int i = 0; i < 16; i++) pool[i] = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 40; i++) begin
      a = {pool[$urandom_range(0, 15)], 4'($urandom_range(0, 15))};
      d = {$urandom, $urandom, $urandom, $urandom};
      if (model.exists(int'(a[15:4])) && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          fa = {pool[$urandom_range(0, 15)], 4'h0};
          run_req(1'b1, fa, 1'b1, a, d, 1'b0, nr, nw, rd);
          model[int'(a[15:4])] = d;
          check_eq("rand_simul_wb_latency", nw, Lat);
          check_eq("rand_simul_fill_latency", nr, 2 * Lat + 2);
          if (model.exists(int'(fa[15:4])))
            check_eq("rand_simul_fill_data", rd, model[int'(fa[15:4])]);
        end else begin
          do_fill(a);
        end
      end else begin
        do_wb(a, d);
      end
    end

    // Minimum-latency instance: write-back then fill of the same line.
    d = 128'hA5A5_0000_FFFF_1111_2222_3333_4444_5A5A;
    req2_wb = 1'b1; req2_wb_addr = 16'h0120; req2_wb_data = d;
    n = 0;
    while (!wb2_done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_eq("lat2_wb_latency", n, 2);
    @(posedge clk);
    #1;
    req2_wb = 1'b0;
    req2_fill = 1'b1; req2_fill_addr = 16'h0127;
    n = 0;
    while (!mem2_data_rdy && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_eq("lat2_fill_latency", n, 3);
    check_eq("lat2_fill_data", data2_to_fill, d);
    @(posedge clk);
    #1;
    req2_fill = 1'b0;
    @(negedge clk);
    check_eq("lat2_idle", mem2_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
